risc_cpu_core: RTL and testbench

// - 8-bit accumulator CPU with 3-bit opcode, 5-bit address and 32x8 unified program/data memory (instance mem1, array memory[0:31]).
// - Each instruction runs a fixed 8-phase sequence of 16 master_clk cycles. Clock/phase generation is internal.
// - Top-level compute block. Benches preload memory hierarchically while rst_ is held or released, before the first fetch completes.

---
 rtl/risc_cpu_core.sv | 197 +++++++++++++++++++
 tb/tb_risc_cpu_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/risc_cpu_core.sv
// risc_cpu_core: 8-bit accumulator CPU with a 3-bit opcode and 5-bit operand address.
// Program and data share one 32x8 memory (instance mem1). Each instruction walks
// through eight two-cycle phases driven by an internal 4-bit phase counter.

module risc_cpu_mem (
    input  logic       master_clk,
    input  logic [4:0] addr,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    // Unified program/data store; deliberately not reset so contents survive rst_.
    logic [7:0] memory [0:31];

    // Single write port, used only when a STO instruction commits its STORE phase.
    always_ff @(posedge master_clk) begin
        if (we) begin
            memory[addr] <= wdata;
        end
    end

    // Reads are combinational so a phase sees data in the same cycle it drives the address.
    assign rdata = memory[addr];
endmodule

module risc_cpu_core (
    input  logic       master_clk,
    input  logic       rst_,
    output logic       halt,
    output logic       load_ir,
    output logic [4:0] pc_addr
);
    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // Instruction phases; each phase spans two master_clk cycles and commits on the odd one.
    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    // Accumulator datapath: ADD drops the carry, LDA passes memory, others hold ACC.
    function automatic logic [7:0] alu_f(input logic [2:0] op,
                                         input logic [7:0] acc,
                                         input logic [7:0] data);
        logic [7:0] res;
        case (op)
            OP_ADD:  res = acc + data;
            OP_AND:  res = acc & data;
            OP_XOR:  res = acc ^ data;
            OP_LDA:  res = data;
            default: res = acc;
        endcase
        return res;
    endfunction

    logic [3:0] cnt_q, cnt_d;
    logic [4:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] acc_q, acc_d;
    logic       halted_q, halted_d;
    logic       load_ir_q, load_ir_d;

    phase_e     phase_s;
    logic       commit_s;
    logic [2:0] opcode_s;
    logic [4:0] op_addr_s;
    logic [4:0] mem_addr_s;
    logic [7:0] mem_rdata_s;
    logic       mem_we_s;
    logic       zero_s;
    logic       aluop_s;

    risc_cpu_mem mem1 (
        .master_clk (master_clk),
        .addr       (mem_addr_s),
        .we         (mem_we_s),
        .wdata      (acc_q),
        .rdata      (mem_rdata_s)
    );

    // Decode the current phase and instruction fields; operand phases address via IR.
    always_comb begin
        phase_s    = phase_e'(cnt_q[3:1]);
        commit_s   = cnt_q[0];
        opcode_s   = ir_q[7:5];
        op_addr_s  = ir_q[4:0];
        zero_s     = (acc_q == 8'h00);
        aluop_s    = (opcode_s == OP_ADD) || (opcode_s == OP_AND) ||
                     (opcode_s == OP_XOR) || (opcode_s == OP_LDA);
        if (cnt_q[3]) begin
            mem_addr_s = op_addr_s;
        end else begin
            mem_addr_s = pc_q;
        end
    end

    // Next-state sequencing: advance the phase counter and apply each phase's commit action.
    always_comb begin
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        halted_d = halted_q;
        mem_we_s = 1'b0;

        if (!halted_q) begin
            cnt_d = cnt_q + 4'd1;
            if (commit_s) begin
                case (phase_s)
                    PH_INST_LOAD, PH_IDLE: begin
                        ir_d = mem_rdata_s;
                    end
                    PH_OP_ADDR: begin
                        pc_d = pc_q + 5'd1;
                        if (opcode_s == OP_HLT) begin
                            halted_d = 1'b1;
                        end else begin
                            halted_d = 1'b0;
                        end
                    end
                    PH_ALU_OP: begin
                        if ((opcode_s == OP_SKZ) && zero_s) begin
                            pc_d = pc_q + 5'd1;
                        end else if (opcode_s == OP_JMP) begin
                            pc_d = op_addr_s;
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    PH_STORE: begin
                        if (aluop_s) begin
                            acc_d = alu_f(opcode_s, acc_q, mem_rdata_s);
                        end else begin
                            acc_d = acc_q;
                        end
                        mem_we_s = (opcode_s == OP_STO);
                        if (opcode_s == OP_JMP) begin
                            pc_d = op_addr_s;
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    PH_INST_ADDR, PH_INST_FETCH, PH_OP_FETCH: begin
                        // Address/fetch phases only steer the memory address.
                        ir_d = ir_q;
                    end
                    default: begin
                        ir_d = ir_q;
                    end
                endcase
            end else begin
                ir_d = ir_q;
            end
        end else begin
            cnt_d = cnt_q;
        end

        // The IR load window covers INST_LOAD and IDLE, i.e. counter values 4..7.
        load_ir_d = (cnt_d[3:2] == 2'b01);
    end

    // State registers; asynchronous reset clears everything except memory.
    always_ff @(posedge master_clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q     <= 4'd0;
            pc_q      <= 5'd0;
            ir_q      <= 8'h00;
            acc_q     <= 8'h00;
            halted_q  <= 1'b0;
            load_ir_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            acc_q     <= acc_d;
            halted_q  <= halted_d;
            load_ir_q <= load_ir_d;
        end
    end

    assign halt    = halted_q;
    assign load_ir = load_ir_q;
    assign pc_addr = pc_q;
endmodule

// File: tb/tb_risc_cpu_core.sv
// tb_risc_cpu_core: directed programs preloaded into mem1; a scoreboard queue holds the
// expected halt PC, halt cycle and result memory words, checked by a separate monitor.

module tb_risc_cpu_core;
    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] LDA = 3'b101;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    logic       master_clk;
    logic       rst_;
    logic       halt;
    logic       load_ir;
    logic [4:0] pc_addr;

    risc_cpu_core dut (
        .master_clk (master_clk),
        .rst_       (rst_),
        .halt       (halt),
        .load_ir    (load_ir),
        .pc_addr    (pc_addr)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    typedef struct packed {
        int         id;
        logic [4:0] pc;
        int         cycles;
        logic [1:0] nmem;
        logic [4:0] ma0;
        logic [7:0] mv0;
        logic [4:0] ma1;
        logic [7:0] mv1;
        logic [4:0] ma2;
        logic [7:0] mv2;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   cyc;

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL t%0d %s: actual %0h required %0h", id, nm, act, expv);
        end
    endtask

    // HLT commits in OP_ADDR of the Nth instruction: 16*(N-1) cycles plus 10 into it.
    function automatic exp_t mk(input int id, input logic [4:0] pc, input int n,
                                input logic [1:0] nm,
                                input logic [4:0] a0, input logic [7:0] v0,
                                input logic [4:0] a1, input logic [7:0] v1,
                                input logic [4:0] a2, input logic [7:0] v2);
        exp_t e;
        e.id = id; e.pc = pc; e.cycles = 16 * (n - 1) + 10; e.nmem = nm;
        e.ma0 = a0; e.mv0 = v0; e.ma1 = a1; e.mv1 = v1; e.ma2 = a2; e.mv2 = v2;
        return e;
    endfunction

    function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] a);
        return {op, a};
    endfunction

    // Count master_clk edges since reset release.
    always @(posedge master_clk or negedge rst_) begin
        if (!rst_) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: checks load_ir every cycle and scores each halt against the queue.
    initial begin : monitor
        logic prev_halt;
        exp_t e;
        prev_halt = 1'b0;
        forever begin
            @(negedge master_clk);
            if (!rst_) begin
                prev_halt = 1'b0;
            end else if (halt && !prev_halt) begin
                prev_halt = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_halt: actual pc %0h required no halt", pc_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("halt_pc", e.id, 32'(pc_addr), 32'(e.pc));
                    check("halt_cycle", e.id, 32'(cyc), 32'(e.cycles));
                    if (e.nmem > 2'd0) check("mem_a", e.id, 32'(dut.mem1.memory[e.ma0]), 32'(e.mv0));
                    if (e.nmem > 2'd1) check("mem_b", e.id, 32'(dut.mem1.memory[e.ma1]), 32'(e.mv1));
                    if (e.nmem > 2'd2) check("mem_c", e.id, 32'(dut.mem1.memory[e.ma2]), 32'(e.mv2));
                    done_cnt++;
                end
            end else if (!halt) begin
                check("load_ir", 0, 32'(load_ir), 32'(((cyc % 16) >= 4) && ((cyc % 16) <= 7)));
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) dut.mem1.memory[i] <= 8'h00;
    endtask

    task automatic poke(input logic [4:0] a, input logic [7:0] v);
        dut.mem1.memory[a] <= v;
    endtask

    task automatic reset_check(input int id);
        #2 rst_ = 1'b0;
        #1;
        check("rst_pc", id, 32'(pc_addr), 32'd0);
        check("rst_halt", id, 32'(halt), 32'd0);
        check("rst_load_ir", id, 32'(load_ir), 32'd0);
    endtask

    task automatic run(input exp_t e);
        int start;
        #1;
        @(negedge master_clk);
        exp_q.push_back(e);
        start = done_cnt;
        rst_ = 1'b1;
        for (int i = 0; i < 2000 && done_cnt == start; i++) @(negedge master_clk);
        if (done_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL t%0d halt_timeout: actual no halt required halt", e.id);
            exp_q.delete();
        end else begin
            repeat (40) @(negedge master_clk);
            check("frozen_pc", e.id, 32'(pc_addr), 32'(e.pc));
            check("frozen_halt", e.id, 32'(halt), 32'd1);
        end
        reset_check(e.id);
    endtask

    task automatic load_prog3();
        clear_mem();
        poke(5'h00, ins(SKZ, 5'h00)); poke(5'h01, ins(JMP, 5'h04));
        poke(5'h02, ins(JMP, 5'h1F)); poke(5'h04, ins(ADD, 5'h1D));
        poke(5'h05, ins(ADD, 5'h1D)); poke(5'h06, ins(STO, 5'h1C));
        poke(5'h07, ins(XOR, 5'h1C)); poke(5'h08, ins(SKZ, 5'h00));
        poke(5'h0A, ins(LDA, 5'h1C)); poke(5'h1D, 8'h07);
        poke(5'h1F, ins(LDA, 5'h1D));
    endtask

    initial begin
        rst_ = 1'b0;
        #1;
        check("init_pc", 0, 32'(pc_addr), 32'd0);
        check("init_halt", 0, 32'(halt), 32'd0);
        check("init_load_ir", 0, 32'(load_ir), 32'd0);

        // LDA/STO/HLT
        clear_mem();
        poke(5'h00, ins(LDA, 5'h1C)); poke(5'h01, ins(STO, 5'h1A));
        poke(5'h02, ins(HLT, 5'h00)); poke(5'h1C, 8'h05);
        run(mk(1, 5'h03, 3, 2'd2, 5'h1A, 8'h05, 5'h1C, 8'h05, 5'h00, 8'h00));

        // SKZ skips the JMP when ACC is zero
        clear_mem();
        poke(5'h00, ins(LDA, 5'h1C)); poke(5'h01, ins(SKZ, 5'h00));
        poke(5'h02, ins(JMP, 5'h00)); poke(5'h03, ins(HLT, 5'h00));
        poke(5'h1C, 8'h00);
        run(mk(2, 5'h04, 3, 2'd1, 5'h1C, 8'h00, 5'h00, 8'h00, 5'h00, 8'h00));

        // ADD wraps FF+01 to 00
        clear_mem();
        poke(5'h00, ins(LDA, 5'h1A)); poke(5'h01, ins(ADD, 5'h1B));
        poke(5'h02, ins(STO, 5'h1C)); poke(5'h03, ins(HLT, 5'h00));
        poke(5'h1A, 8'hFF); poke(5'h1B, 8'h01); poke(5'h1C, 8'h77);
        run(mk(3, 5'h04, 4, 2'd2, 5'h1C, 8'h00, 5'h1A, 8'hFF, 5'h00, 8'h00));

        // Program 1: jumps, SKZ both ways, XOR, HLT at 16
        clear_mem();
        poke(5'h00, ins(JMP, 5'h1E)); poke(5'h03, ins(LDA, 5'h1A));
        poke(5'h04, ins(SKZ, 5'h00)); poke(5'h06, ins(LDA, 5'h1B));
        poke(5'h07, ins(SKZ, 5'h00)); poke(5'h08, ins(JMP, 5'h0A));
        poke(5'h0A, ins(STO, 5'h1C)); poke(5'h0B, ins(LDA, 5'h1A));
        poke(5'h0C, ins(STO, 5'h1C)); poke(5'h0D, ins(LDA, 5'h1C));
        poke(5'h0E, ins(SKZ, 5'h00)); poke(5'h10, ins(XOR, 5'h1B));
        poke(5'h11, ins(SKZ, 5'h00)); poke(5'h12, ins(JMP, 5'h14));
        poke(5'h14, ins(XOR, 5'h1A)); poke(5'h15, ins(SKZ, 5'h00));
        poke(5'h1A, 8'h00); poke(5'h1B, 8'hFF); poke(5'h1C, 8'hAA);
        poke(5'h1E, ins(JMP, 5'h03));
        run(mk(4, 5'h17, 18, 2'd3, 5'h1C, 8'h00, 5'h1A, 8'h00, 5'h1B, 8'hFF));

        // Program 2: counting loop, AND/XOR, HLT at 0F
        clear_mem();
        poke(5'h00, ins(LDA, 5'h1C)); poke(5'h01, ins(ADD, 5'h1B));
        poke(5'h02, ins(STO, 5'h1C)); poke(5'h03, ins(SKZ, 5'h00));
        poke(5'h04, ins(JMP, 5'h01)); poke(5'h05, ins(LDA, 5'h1D));
        poke(5'h06, ins(AND, 5'h1E)); poke(5'h07, ins(STO, 5'h19));
        poke(5'h08, ins(XOR, 5'h1E)); poke(5'h09, ins(STO, 5'h18));
        poke(5'h0A, ins(AND, 5'h1A)); poke(5'h0B, ins(SKZ, 5'h00));
        poke(5'h0D, ins(JMP, 5'h0F));
        poke(5'h1A, 8'h00); poke(5'h1B, 8'h01); poke(5'h1C, 8'hFD);
        poke(5'h1D, 8'hF0); poke(5'h1E, 8'h3C);
        run(mk(5, 5'h10, 21, 2'd3, 5'h1C, 8'h00, 5'h19, 8'h30, 5'h18, 8'h0C));

        // Program 3 interrupted by reset mid-instruction, then rerun from address 0
        load_prog3();
        #1;
        @(negedge master_clk);
        rst_ = 1'b1;
        repeat (100) @(negedge master_clk);
        reset_check(6);
        load_prog3();
        run(mk(7, 5'h0C, 12, 2'd1, 5'h1C, 8'h15, 5'h00, 8'h00, 5'h00, 8'h00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
